// File: rtl/async_fifo_rd_stream_if.sv
// +----------------------------------------------------------------------------+
// | async_fifo_rd_stream_if                                                    |
// | FIFO pop port plus valid/ready output stream of the read-side consumer.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface async_fifo_rd_stream_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );
endinterface

`default_nettype wire

// File: rtl/async_fifo_rd_stream.sv
// +----------------------------------------------------------------------------+
// | async_fifo_rd_stream                                                       |
// | Pops an async FIFO (rd_clk domain) into a skid buffer and streams it out   |
// | as valid/ready. Define FIFO_RD_LAST_EN to generate m_last per BURST_LEN.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module async_fifo_rd_stream #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 4,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  wire logic               rd_clk,
  input  wire logic               n_rst,
  input  wire logic               enable,
  async_fifo_rd_stream_if.master  bus,
  output logic                    busy,
  output logic [CNT_W-1:0]        word_cnt
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_run   = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;

  localparam logic [PTR_W+1:0] c_depth = (PTR_W+2)'(BUF_DEPTH);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_buf [BUF_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_occ;
  logic              r_infl;
  logic [CNT_W-1:0]  r_word_cnt;

  logic              w_room;
  logic              w_pop;
  logic              w_valid;
  logic              w_xfer;

  // Reserve a slot for the word still in flight so the buffer never overflows.
  assign w_room  = ({1'b0, r_occ} + {{(PTR_W+1){1'b0}}, r_infl}) < c_depth;
  assign w_pop   = (r_state == c_run) & ~bus.fifo_empty & w_room;
  assign w_valid = (r_occ != '0);
  assign w_xfer  = w_valid & bus.m_ready;

  assign bus.fifo_rd_en = w_pop;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = r_buf[r_rd_ptr];
  assign busy           = (r_state != c_idle);
  assign word_cnt       = r_word_cnt;

  always_ff @(posedge rd_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= c_idle;
    end else begin
      case (r_state)
        c_idle:  if (enable) r_state <= c_run;
        c_run:   if (!enable) r_state <= c_drain;
        c_drain: begin
          if (enable)
            r_state <= c_run;
          else if ((r_occ == '0) && !r_infl)
            r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  // FIFO data is registered: a pop in one cycle is captured at the end of the next.
  always_ff @(posedge rd_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_infl   <= 1'b0;
      r_wr_ptr <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_infl <= w_pop;
      if (r_infl) begin
        r_buf[r_wr_ptr] <= bus.fifo_dout;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge rd_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_word_cnt <= '0;
    end else begin
      if (w_xfer) begin
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
      case ({r_infl, w_xfer})
        2'b10:   r_occ <= r_occ + (PTR_W+1)'(1);
        2'b01:   r_occ <= r_occ - (PTR_W+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef FIFO_RD_LAST_EN
  localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BC_W-1:0] c_burst_max = BC_W'(BURST_LEN - 1);

  logic [BC_W-1:0] r_burst_cnt;

  always_ff @(posedge rd_clk or negedge n_rst) begin
    if (!n_rst)
      r_burst_cnt <= '0;
    else if (w_xfer)
      r_burst_cnt <= (r_burst_cnt == c_burst_max) ? '0 : r_burst_cnt + BC_W'(1);
  end

  assign bus.m_last = w_valid & (r_burst_cnt == c_burst_max);
`else
  assign bus.m_last = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_async_fifo_rd_stream.sv
// +----------------------------------------------------------------------------+
// | tb_async_fifo_rd_stream                                                    |
// | Directed scoreboard bench with a behavioural FIFO model feeding the DUT.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_async_fifo_rd_stream;

  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 4;
  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 16;

  logic             rd_clk = 1'b0;
  logic             n_rst;
  logic             enable;
  logic             busy;
  logic [CNT_W-1:0] word_cnt;
  logic             empty_force;

  async_fifo_rd_stream_if #(.DATA_W(DATA_W)) bus ();

  async_fifo_rd_stream #(
    .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)
  ) dut (
    .rd_clk(rd_clk), .n_rst(n_rst), .enable(enable), .bus(bus),
    .busy(busy), .word_cnt(word_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] fifo_q [$];
  logic [DATA_W-1:0] exp_q  [$];
  int  fifo_cnt = 0;
  logic pop_pend = 1'b0;

  // monitor bookkeeping
  int cyc = 0, pop_n = 0, xfer_n = 0, xfer_rst = 0, last_n = 0;
  int first_pop = -1, first_valid = -1, first_xfer = -1, last_xfer = -1;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  assign bus.fifo_empty = (fifo_cnt == 0) || empty_force;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
    fifo_cnt++;
  endtask

  // Behavioural FIFO: registered read data, valid the cycle after a pop.
  always @(posedge rd_clk) begin
    if (pop_pend && fifo_cnt > 0) begin
      bus.fifo_dout <= fifo_q.pop_front();
      fifo_cnt--;
    end
  end

  // Sample one time unit before each active edge.
  always begin
    @(negedge rd_clk);
    #4;
    cyc++;
    pop_pend = bus.fifo_rd_en && !bus.fifo_empty;
    if (bus.fifo_rd_en) begin
      chk("rd_en_while_empty", bus.fifo_empty, 1'b0);
      pop_n++;
      if (first_pop < 0) first_pop = cyc;
    end
    if (bus.m_valid && first_valid < 0) first_valid = cyc;
    if (prev_stall) chk("data_stable", bus.m_data, prev_data);
    if (!bus.m_valid) chk("last_idle", bus.m_last, 1'b0);
    if (bus.m_valid && bus.m_ready) begin
      chk("xfer_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("xfer_data", bus.m_data, exp_q.pop_front());
`ifdef FIFO_RD_LAST_EN
      chk("m_last", bus.m_last, (xfer_rst % BURST_LEN) == BURST_LEN - 1);
`else
      chk("m_last", bus.m_last, 1'b0);
`endif
      if (bus.m_last) last_n++;
      xfer_n++;
      xfer_rst++;
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
    end
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_data  = bus.m_data;
  end

  task automatic step_clear();
    pop_n = 0; xfer_n = 0; last_n = 0;
    first_pop = -1; first_valid = -1; first_xfer = -1; last_xfer = -1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i;
    for (i = 0; i < budget && exp_q.size() != 0; i++) @(negedge rd_clk);
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    n_rst = 1'b0; enable = 1'b0; bus.m_ready = 1'b0; empty_force = 1'b0;
    bus.fifo_dout = '0;
    repeat (3) @(negedge rd_clk);
    chk("rst_valid", bus.m_valid, 1'b0);
    chk("rst_rd_en", bus.fifo_rd_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_word_cnt", word_cnt, 0);
    n_rst = 1'b1;
    @(negedge rd_clk);

    // Full-rate streaming of a preloaded FIFO
    for (int i = 1; i <= 16; i++) push(DATA_W'(i));
    step_clear();
    enable = 1'b1; bus.m_ready = 1'b1;
    begin
      int i;
      for (i = 0; i < 100 && xfer_n < 16; i++) @(negedge rd_clk);
    end
    chk("stream_count", xfer_n, 16);
    chk("pop_to_valid", first_valid - first_pop, 2);
    chk("stream_span", last_xfer - first_xfer, 15);
    chk("stream_word_cnt", word_cnt, 16);
    chk("stream_empty", exp_q.size(), 0);

    // Back-pressure fills the skid buffer and stops popping
    bus.m_ready = 1'b0;
    step_clear();
    for (int i = 1; i <= 10; i++) push(DATA_W'(i));
    repeat (12) @(negedge rd_clk);
    chk("bp_pops", pop_n, BUF_DEPTH);
    chk("bp_rd_en", bus.fifo_rd_en, 1'b0);
    chk("bp_valid", bus.m_valid, 1'b1);
    chk("bp_data", bus.m_data, 8'h01);
    bus.m_ready = 1'b1;
    wait_drain("bp_drain", 100);
    chk("bp_word_cnt", word_cnt, 26);

    // Drop enable with a pop in flight
    step_clear();
    for (int i = 0; i < 20; i++) push(DATA_W'(8'h40 + i));
    begin
      int i;
      for (i = 0; i < 100 && xfer_n < 5; i++) @(negedge rd_clk);
    end
    chk("drain_start", xfer_n, 5);
    enable = 1'b0;
    begin
      int i;
      for (i = 0; i < 100 && busy; i++) @(negedge rd_clk);
    end
    chk("drain_busy", busy, 1'b0);
    chk("drain_delivered", exp_q.size(), fifo_cnt);
    pop_n = 0;
    repeat (5) @(negedge rd_clk);
    chk("drain_no_pop", pop_n, 0);
    enable = 1'b1;
    wait_drain("drain_rest", 100);
    chk("drain_word_cnt", word_cnt, 46);

    // Flickering empty flag
    for (int i = 0; i < 12; i++) push(DATA_W'(8'h80 + i * 3));
    begin
      int i;
      for (i = 0; i < 200 && exp_q.size() != 0; i++) begin
        @(negedge rd_clk);
        empty_force = ~empty_force;
      end
    end
    chk("flicker_drain", exp_q.size(), 0);
    empty_force = 1'b0;
    repeat (3) @(negedge rd_clk);
    chk("flicker_word_cnt", word_cnt, 58);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 10; i++) push(DATA_W'(8'hC0 + i));
    repeat (4) @(negedge rd_clk);
    #1 n_rst = 1'b0;
    #1;
    chk("mid_rst_valid", bus.m_valid, 1'b0);
    chk("mid_rst_rd_en", bus.fifo_rd_en, 1'b0);
    chk("mid_rst_data", bus.m_data, 0);
    chk("mid_rst_last", bus.m_last, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_word_cnt", word_cnt, 0);
    fifo_q.delete(); exp_q.delete(); fifo_cnt = 0; xfer_rst = 0;
    @(negedge rd_clk);
    n_rst = 1'b1;
    @(negedge rd_clk);

    // Burst marker over 12 words
    step_clear();
    for (int i = 1; i <= 12; i++) push(DATA_W'(i));
    wait_drain("burst_drain", 100);
    repeat (2) @(negedge rd_clk);
`ifdef FIFO_RD_LAST_EN
    chk("burst_last_count", last_n, 3);
`else
    chk("burst_last_count", last_n, 0);
`endif
    chk("burst_word_cnt", word_cnt, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
